// File: rtl/mips_multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl_if
// Purpose  : Bundles the signals between the multicycle MIPS controller and
//            its datapath. These are the instruction fields, the ALU Zero
//            flag, the memory ready handshake and every datapath control.
// Modports : master - controller side (drives controls, reads IR/flags)
//            slave  - datapath side  (drives IR/flags, reads controls)
// Signals  : opcode[5:0], funct[5:0], Zero, mem_ready      (datapath -> ctrl)
//            operation[3:0], ALUSrcA, ALUSrcB[1:0], PCSource[1:0], pc_en,
//            IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg
//                                                          (ctrl -> datapath)
// Revision : 1.0 - initial release
// ============================================================================
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       Zero;
    logic       mem_ready;
    logic [3:0] operation;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic       pc_en;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       RegDst;
    logic       MemtoReg;

    modport master (
        input  opcode, funct, Zero, mem_ready,
        output operation, ALUSrcA, ALUSrcB, PCSource, pc_en,
               IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg
    );

    modport slave (
        output opcode, funct, Zero, mem_ready,
        input  operation, ALUSrcA, ALUSrcB, PCSource, pc_en,
               IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg
    );
endinterface
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl
// Purpose  : Main controller FSM for a multicycle MIPS datapath. It sequences
//            fetch/decode/execute/memory/writeback, drives the ALU operation
//            and source selects, gates PC/IR loads and counts retired
//            instructions.
// Ports    : clk      - clock, all state changes on the rising edge
//            rst_n    - asynchronous active-low reset
//            dp       - mips_multicycle_ctrl_if.master datapath bundle
//            illegal  - one-cycle flag for an unsupported opcode or funct
//            retired  - count of completed instructions (wraps)
// Params   : CNT_W    - width of the retired-instruction counter
// Options  : MIPS_CTRL_BNE_EN - when defined, opcode 000101 (bne) is
//            executed. Otherwise it is reported as illegal.
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    mips_multicycle_ctrl_if.master dp,
    output logic                   illegal,
    output logic [CNT_W-1:0]       retired
);

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    // ALU operation codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_ADDI_EX  = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BEQ_EX   = 4'd9,
        S_J_EX     = 4'd10
`ifdef MIPS_CTRL_BNE_EN
        , S_BNE_EX = 4'd11
`endif
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [3:0] funct_op;
    logic       funct_ok;
    logic       retire_now;

    // R-type funct decode. It is used both in RTYPE_EX (operation and
    // illegal) and in ALU_WB (to suppress the register write).
    always_comb begin
        funct_op = ALU_ADD;
        funct_ok = 1'b1;
        case (dp.funct)
            6'b100000: funct_op = ALU_ADD;
            6'b100010: funct_op = ALU_SUB;
            6'b100100: funct_op = ALU_AND;
            6'b100101: funct_op = ALU_OR;
            6'b100110: funct_op = ALU_XOR;
            6'b100111: funct_op = ALU_NOR;
            6'b101010: funct_op = ALU_SLT;
            default:   funct_ok = 1'b0;
        endcase
    end

    // State register. Because outputs are decoded from state, an async
    // reset immediately yields FETCH outputs and drops MemWrite mid-access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and output decode
    always_comb begin
        next_state   = state;
        dp.operation = ALU_ADD;
        dp.ALUSrcA   = 1'b0;
        dp.ALUSrcB   = 2'b00;
        dp.PCSource  = 2'b00;
        dp.pc_en     = 1'b0;
        dp.IorD      = 1'b0;
        dp.MemRead   = 1'b0;
        dp.MemWrite  = 1'b0;
        dp.IRWrite   = 1'b0;
        dp.RegWrite  = 1'b0;
        dp.RegDst    = 1'b0;
        dp.MemtoReg  = 1'b0;
        illegal      = 1'b0;
        retire_now   = 1'b0;

        case (state)
            S_FETCH: begin
                dp.MemRead = 1'b1;
                dp.ALUSrcB = 2'b01;
                // PC+4 and the IR load both complete with the memory read
                dp.IRWrite = dp.mem_ready;
                dp.pc_en   = dp.mem_ready;
                if (dp.mem_ready) begin
                    next_state = S_DECODE;
                end
            end

            S_DECODE: begin
                // Branch target precomputed into ALUOut
                dp.ALUSrcB = 2'b11;
                case (dp.opcode)
                    OP_RTYPE:      next_state = S_RTYPE_EX;
                    OP_LW, OP_SW:  next_state = S_MEMADR;
                    OP_BEQ:        next_state = S_BEQ_EX;
                    OP_ADDI:       next_state = S_ADDI_EX;
                    OP_J:          next_state = S_J_EX;
`ifdef MIPS_CTRL_BNE_EN
                    OP_BNE:        next_state = S_BNE_EX;
`endif
                    default: begin
                        illegal    = 1'b1;
                        next_state = S_FETCH;
                    end
                endcase
            end

            S_MEMADR: begin
                dp.ALUSrcA = 1'b1;
                dp.ALUSrcB = 2'b10;
                next_state = (dp.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end

            S_MEMRD: begin
                dp.MemRead = 1'b1;
                dp.IorD    = 1'b1;
                if (dp.mem_ready) begin
                    next_state = S_MEMWB;
                end
            end

            S_MEMWB: begin
                dp.RegWrite = 1'b1;
                dp.MemtoReg = 1'b1;
                retire_now  = 1'b1;
                next_state  = S_FETCH;
            end

            S_MEMWR: begin
                dp.MemWrite = 1'b1;
                dp.IorD     = 1'b1;
                if (dp.mem_ready) begin
                    retire_now = 1'b1;
                    next_state = S_FETCH;
                end
            end

            S_RTYPE_EX: begin
                dp.ALUSrcA   = 1'b1;
                dp.operation = funct_op;
                illegal      = ~funct_ok;
                next_state   = S_ALU_WB;
            end

            S_ADDI_EX: begin
                dp.ALUSrcA = 1'b1;
                dp.ALUSrcB = 2'b10;
                next_state = S_ALU_WB;
            end

            S_ALU_WB: begin
                dp.RegDst = (dp.opcode == OP_RTYPE);
                // An R-type with an unknown funct retires without a write
                dp.RegWrite = (dp.opcode != OP_RTYPE) | funct_ok;
                retire_now  = 1'b1;
                next_state  = S_FETCH;
            end

            S_BEQ_EX: begin
                dp.ALUSrcA   = 1'b1;
                dp.operation = ALU_SUB;
                dp.PCSource  = 2'b01;
                dp.pc_en     = dp.Zero;
                retire_now   = 1'b1;
                next_state   = S_FETCH;
            end

`ifdef MIPS_CTRL_BNE_EN
            S_BNE_EX: begin
                dp.ALUSrcA   = 1'b1;
                dp.operation = ALU_SUB;
                dp.PCSource  = 2'b01;
                dp.pc_en     = ~dp.Zero;
                retire_now   = 1'b1;
                next_state   = S_FETCH;
            end
`endif

            S_J_EX: begin
                dp.PCSource = 2'b10;
                dp.pc_en    = 1'b1;
                retire_now  = 1'b1;
                next_state  = S_FETCH;
            end

            default: begin
                next_state = S_FETCH;
            end
        endcase
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= '0;
        end else if (retire_now) begin
            retired <= retired + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multicycle MIPS main controller FSM; the initiator side of the ALU interface.
- Sequences fetch/decode/execute/memory/writeback, drives the ALU `operation` code and the SrcA/SrcB mux selects, and consumes the ALU `Zero` flag for branches.
- Sits between the instruction register and the datapath muxes/enables; handshakes with memory via `mem_ready`.
- Also counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]; stable after FETCH completes
- funct  in  6  IR[5:0]
- Zero  in  1  ALU equality flag
- mem_ready  in  1  memory completes current access this cycle
- operation  out  4  ALU code: ADD 0010, SUB 0110, AND 0000, OR 0001, NOR 1100, XOR 0011, SLT 0111
- ALUSrcA  out  1  0=PC, 1=regA
- ALUSrcB  out  2  00=regB, 01=const 4, 10=sign-ext imm, 11=imm<<2
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
- pc_en  out  1  PC load = PCWrite | (Branch & Zero)
- IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg  out  1 each  datapath controls
- illegal  out  1  one-cycle flag on unsupported opcode/funct
- retired  out  CNT_W  instructions completed

Behaviour:
- Moore outputs decoded from state, except pc_en/IRWrite in FETCH and pc_en in BEQ_EX. Every output not listed for a state is 0; operation defaults to ADD.
- Reset (async, rst_n=0):
  - state=FETCH, retired=0.
  - Outputs take FETCH decode with mem_ready gating. MemWrite drops immediately if reset hits during MEMWR.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ADD, PCSource=00.
  - IRWrite=pc_en=mem_ready.
  - Holds while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ADD.
  - Next state by opcode: 000000→RTYPE_EX; 100011/101011→MEMADR; 000100→BEQ_EX; 001000→ADDI_EX; 000010→J_EX.
  - Any other opcode: illegal=1 this cycle, →FETCH, retired not incremented.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ADD; →MEMRD (lw) or MEMWR (sw).
- MEMRD: MemRead=1, IorD=1; wait for mem_ready, then →MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1; →FETCH.
- MEMWR: MemWrite=1, IorD=1; wait for mem_ready, then →FETCH.
- RTYPE_EX:
  - ALUSrcA=1, ALUSrcB=00.
  - Funct decode: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT.
  - Unknown funct: operation=ADD, illegal=1.
  - →ALU_WB.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, ADD; →ALU_WB.
- ALU_WB:
  - MemtoReg=0; RegDst=1 if opcode=000000, else 0.
  - RegWrite=1, except 0 for R-type with unknown funct.
  - →FETCH.
- BEQ_EX: ALUSrcA=1, ALUSrcB=00, SUB, PCSource=01, pc_en=Zero; →FETCH.
- J_EX: PCSource=10, pc_en=1; →FETCH.
- retired:
  - Increments by 1 on every transition into FETCH from MEMWB, MEMWR, ALU_WB, BEQ_EX or J_EX.
  - Not incremented on illegal opcode; an unknown funct still counts.
  - Wraps 2^CNT_W−1→0.
- mem_ready is ignored in states without a memory access.
- Opcode/funct changes are assumed only while in FETCH; they are sampled every cycle.
- Cycle counts: lw 5, sw 4, R/addi 4, beq 3, j 3 (plus memory wait cycles).

Optional Feature:
- Macro MIPS_CTRL_BNE_EN.
- Defined: opcode 000101 in DECODE →BNE_EX. BNE_EX is identical to BEQ_EX except pc_en=~Zero; retired increments on exit.
- Undefined: 000101 is illegal (illegal=1 in DECODE, →FETCH).

Test Plan:
- rst_n low mid-MEMWR with MemWrite=1 → MemWrite=0 the same cycle, state FETCH, retired=0, MemRead=1.
- Fetch with mem_ready low 3 cycles then high → IRWrite/pc_en=0 for 3 cycles, 1 on cycle 4, DECODE next.
- R-type funct 100010 → RTYPE_EX operation=0110, ALU_WB RegWrite=1 RegDst=1, retired +1; funct 111111 → illegal=1, RegWrite=0 in ALU_WB.
- lw with mem_ready=1 throughout → 5 cycles FETCH,DECODE,MEMADR,MEMRD,MEMWB; MEMWB MemtoReg=1 RegWrite=1.
- beq with Zero=1 → BEQ_EX pc_en=1 PCSource=01 operation=0110; Zero=0 → pc_en=0; both increment retired.
- opcode 000101: macro undefined → illegal=1 and retired unchanged; defined with Zero=0 → pc_en=1.
